// File: rtl/uart_imem_loader.sv
// UART boot loader: receives 8N1 bytes and packs them little-endian
// into 32-bit words written to instruction memory at consecutive addresses.
module uart_imem_loader #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        en,
    input  logic        restart,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] wd,
    output logic        busy,
    output logic        frame_err
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = (DIV / 2 > 0) ? DIV / 2 : 1;
    localparam int TW   = $clog2(DIV + 1);
    localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state;
    state_t state_nx;

    logic              rx_m;
    logic              rx_s;
    logic              rx_d;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic              we_r;

    logic fall;
    logic t_half;
    logic t_full;
    logic bit_take;
    logic stop_ok;
    logic stop_bad;

    // rx_d tracks the previous synchronized level for edge detection;
    // all three reset high so reset release never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall   = en & rx_d & ~rx_s;
    assign t_half = (timer == T_HALF);
    assign t_full = (timer == T_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (fall) state_nx = START;
                START: if (t_half) state_nx = rx_s ? IDLE : DATA;
                DATA:  if (t_full && bit_cnt == 3'd7) state_nx = STOP;
                STOP:  if (t_full) state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        bit_take = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        if (en) begin
            unique case (state)
                IDLE:  ;
                START: ;
                DATA:  bit_take = t_full;
                STOP: begin
                    stop_ok  = t_full & rx_s;
                    stop_bad = t_full & ~rx_s;
                end
            endcase
        end
    end

    // timer restarts on every state change so each state measures from entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            if (!en || state == IDLE || state_nx != state || t_full)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (!en || state != DATA)
                bit_cnt <= '0;
            else if (bit_take)
                bit_cnt <= bit_cnt + 1'b1;

            if (bit_take)
                shift <= {rx_s, shift[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd        <= '0;
            we_r      <= 1'b0;
            byte_idx  <= '0;
            word_idx  <= '0;
            frame_err <= 1'b0;
        end else begin
            we_r <= stop_ok && (byte_idx == 2'd3);

            if (stop_ok)
                wd[{byte_idx, 3'b000} +: 8] <= shift;

            if (restart || !en)
                byte_idx <= '0;
            else if (stop_ok)
                byte_idx <= byte_idx + 1'b1;

            // restart wins over the post-strobe increment
            if (restart)
                word_idx <= '0;
            else if (we)
                word_idx <= word_idx + 1'b1;

            if (restart)
                frame_err <= 1'b0;
            else if (stop_bad)
                frame_err <= 1'b1;
        end
    end

    assign we   = we_r & en;
    assign addr = 32'({word_idx, 2'b00});
    assign busy = (state != IDLE) || (byte_idx != 2'd0);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: table-driven words with a
// strobe scoreboard, plus hand-written corner-case sequences.
module tb_uart_imem_loader;

    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        en = 1'b1;
    logic        en2 = 1'b0;
    logic        restart = 1'b0;
    logic        we, we2;
    logic [31:0] addr, addr2, wd, wd2;
    logic        busy, busy2, frame_err, ferr2;

    always #5 clk = ~clk;

    uart_imem_loader #(.CLK_HZ(16), .BAUD(1), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst_n), .rx(rx), .en(en), .restart(restart),
        .we(we), .addr(addr), .wd(wd), .busy(busy), .frame_err(frame_err)
    );

    uart_imem_loader #(.CLK_HZ(16), .BAUD(1), .ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst_n), .rx(rx), .en(en2), .restart(restart),
        .we(we2), .addr(addr2), .wd(wd2), .busy(busy2), .frame_err(ferr2)
    );

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_wd;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    vec_t tv[4];
    exp_t q1[$];
    exp_t q2[$];
    int   w1 = 0;
    int   w2 = 0;
    int   n_pass = 0;
    int   n_total = 0;

    bit          chk_nxt = 1'b0;
    bit          rs_q = 1'b0;
    logic [31:0] nxt_addr = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_word(input logic [31:0] d);
        q1.push_back({32'((w1 % 256) * 4), d});
        w1++;
        if (en2) begin
            q2.push_back({32'((w2 % 4) * 4), d});
            w2++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_hi,
                             input bit rs_on_we);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_hi;
        for (int i = 0; i < DIV; i++) begin
            @(negedge clk);
            if (rs_on_we && we) begin
                restart = 1'b1;
                @(negedge clk);
                restart = 1'b0;
                i++;
            end
        end
        rx = 1'b1;
        if (!stop_hi) repeat (DIV) @(negedge clk);
    endtask

    task automatic send_vec(input vec_t v, input bit rs_last);
        push_word(v.exp_wd);
        send_byte(v.b0, 1'b1, 1'b0);
        send_byte(v.b1, 1'b1, 1'b0);
        send_byte(v.b2, 1'b1, 1'b0);
        send_byte(v.b3, 1'b1, rs_last);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(q1.size() + q2.size()), 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        rs_q = restart;
    end

    // scoreboard for the 8-bit-index instance, including post-strobe step
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (chk_nxt) begin
            check("addr_step", addr, rs_q ? 32'h0 : nxt_addr);
            check("we_one_cycle", {31'b0, we}, 32'h0);
            chk_nxt = 1'b0;
        end else if (we) begin
            if (q1.size() == 0) begin
                check("spurious_we", {31'b0, we}, 32'h0);
            end else begin
                e = q1.pop_front();
                check("strobe_addr", addr, e.a);
                check("strobe_wd", wd, e.d);
                nxt_addr = (e.a + 32'd4) & 32'h3FC;
                chk_nxt = 1'b1;
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (we2) begin
            if (q2.size() == 0) begin
                check("spurious_we2", {31'b0, we2}, 32'h0);
            end else begin
                e = q2.pop_front();
                check("strobe2_addr", addr2, e.a);
                check("strobe2_wd", wd2, e.d);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tv[0] = '{8'h13, 8'h00, 8'h00, 8'h00, 32'h0000_0013};
        tv[1] = '{8'h93, 8'h00, 8'h50, 8'h00, 32'h0050_0093};
        tv[2] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h1234_5678};
        tv[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF_00FF};

        repeat (3) @(negedge clk);
        check("rst_we", {31'b0, we}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_wd", wd, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_ferr", {31'b0, frame_err}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_false_start", {31'b0, busy}, 32'h0);

        for (int i = 0; i < 4; i++) send_vec(tv[i], 1'b0);
        drain("table_drain");
        check("table_busy", {31'b0, busy}, 32'h0);
        check("table_ferr", {31'b0, frame_err}, 32'h0);

        push_word(32'hCCBB_AA11);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'hBB, 1'b1, 1'b0);
        send_byte(8'hCC, 1'b1, 1'b0);
        drain("ferr_drain");
        check("ferr_set", {31'b0, frame_err}, 32'h1);

        pulse_restart();
        w1 = 0;
        check("restart_ferr", {31'b0, frame_err}, 32'h0);
        check("restart_addr", addr, 32'h0);

        rx = 1'b0;
        repeat (3) @(negedge clk);
        check("glitch_busy_hi", {31'b0, busy}, 32'h1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_lo", {31'b0, busy}, 32'h0);
        check("glitch_addr", addr, 32'h0);

        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        check("part_busy", {31'b0, busy}, 32'h1);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("en_busy", {31'b0, busy}, 32'h0);
        check("en_addr", addr, 32'h0);
        en = 1'b1;
        send_vec('{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBE_ADDE}, 1'b0);
        drain("en_drain");

        send_vec('{8'h44, 8'h33, 8'h22, 8'h11, 32'h1122_3344}, 1'b1);
        drain("rs_drain");
        w1 = 0;
        check("rs_addr", addr, 32'h0);

        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h66, 1'b1, 1'b0);
        rx = 1'b0;
        repeat (DIV + 20) @(negedge clk);
        check("mid_busy", {31'b0, busy}, 32'h1);
        check("mid_wd", {16'h0, wd[15:0]}, 32'h0000_6655);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", {31'b0, we}, 32'h0);
        check("arst_wd", wd, 32'h0);
        check("arst_busy", {31'b0, busy}, 32'h0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_vec('{8'h9A, 8'hBC, 8'hDE, 8'hF0, 32'hF0DE_BC9A}, 1'b0);
        drain("arst_drain");

        en2 = 1'b1;
        pulse_restart();
        w1 = 0;
        w2 = 0;
        for (int i = 0; i < 5; i++) send_vec(tv[i % 4], 1'b0);
        drain("wrap_drain");
        check("wrap_addr2", addr2, 32'h4);
        check("wrap_addr", addr, 32'h14);
        check("wrap_busy", {31'b0, busy2}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
